// File: rtl/tx_frame_scheduler_if.sv
// Word-level link between the receiver, the frame scheduler and the BPSK modulator.
// The receiver side pushes words in; the scheduler drives the modulator side.
interface tx_frame_scheduler_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_done;
    logic [DATA_WIDTH:0]   rx_data;
    logic                  mod_en;
    logic [DATA_WIDTH:0]   mod_data;

    modport master (
        output rx_done,
        output rx_data,
        input  mod_en,
        input  mod_data
    );

    modport slave (
        input  rx_done,
        input  rx_data,
        output mod_en,
        output mod_data
    );
endinterface

// File: rtl/tx_frame_scheduler.sv
// Queues received words in a small FIFO and plays them to the modulator one
// frame at a time: LOAD, a fixed mod_en window, then an optional idle gap.
module tx_frame_scheduler #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_AW      = 2,
    parameter int FRAME_CYCLES = 64,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                   clk,
    input  logic                   arst,
    tx_frame_scheduler_if.slave    bus,
    input  logic                   tx_enable,
    input  logic                   ovf_clr,
    output logic                   busy,
    output logic [FIFO_AW:0]       fifo_level,
    output logic                   overflow,
    output logic [15:0]            frames_sent
);
    localparam int W       = DATA_WIDTH + 1;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int PTR_W   = (FIFO_AW > 0) ? FIFO_AW : 1;
    localparam int LVL_W   = FIFO_AW + 1;
    localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [W-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q;
    logic [W-1:0]       mod_data_q;
    logic               overflow_q;
    logic [15:0]        frames_cnt_q;

    logic               full, pop, push, drop, frame_done;

    // A pop frees the slot the simultaneous push lands in, so a full FIFO
    // still accepts a word in the cycle the scheduler takes the head.
    assign full = (level_q == LVL_FULL);
    assign push = bus.rx_done && (!full || pop);
    assign drop = bus.rx_done && full && !pop;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pop        = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (level_q != '0 && tx_enable) begin
                    pop     = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = FRAME_LOAD;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (cnt_q == '0) begin
                    frame_done = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        cnt_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers and level, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            mod_data_q   <= '0;
            overflow_q   <= 1'b0;
            frames_cnt_q <= '0;
        end else begin
            if (pop) begin
                mod_data_q <= mem[rd_ptr_q];
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
            if (frame_done) begin
                frames_cnt_q <= frames_cnt_q + 1'b1;
            end
        end
    end

    assign bus.mod_en   = (state_q == ST_SEND);
    assign bus.mod_data = mod_data_q;
    assign busy         = (state_q != ST_IDLE);
    assign fifo_level   = level_q;
    assign overflow     = overflow_q;
    assign frames_sent  = frames_cnt_q;
endmodule
